// File: rtl/req_encoder_32x5.sv
// Sequential 32-to-5 request encoder: captures a masked request vector, then hands out the index
// of each set bit per handshake and pulses o_done once the vector is exhausted.
module req_encoder_32x5 #(
  parameter bit          MSB_FIRST = 1'b0,
  parameter logic [31:0] MASK      = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_d,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [4:0]  o_idx,
  output logic        o_busy,
  output logic        o_done,
  output logic [5:0]  o_count
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StFin  = 2'd2
  } state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_pend, w_pend_d;
  logic [31:0] w_masked;
  logic [4:0]  w_sel;
  logic [5:0]  w_pop;

  assign w_masked = i_d & MASK;

  // Priority select: the last match in loop order wins.
  always_comb begin
    w_sel = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 32; i++) begin
        if (r_pend[i]) w_sel = 5'(i);
      end
    end else begin
      for (int i = 31; i >= 0; i--) begin
        if (r_pend[i]) w_sel = 5'(i);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 32; i++) begin
      w_pop = w_pop + {5'd0, r_pend[i]};
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_pend_d  = r_pend;
    unique case (r_state)
      StIdle: begin
        if (i_load) begin
          w_pend_d  = w_masked;
          w_state_d = (w_masked != '0) ? StScan : StFin;
        end
      end
      StScan: begin
        if (i_ready) begin
          w_pend_d[w_sel] = 1'b0;
          if (w_pend_d == '0) w_state_d = StFin;
        end
      end
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State advances on the falling edge to match the surrounding registers.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_d;
      r_pend  <= w_pend_d;
    end
  end

  assign o_valid = (r_state == StScan);
  assign o_idx   = o_valid ? w_sel : 5'd0;
  assign o_busy  = (r_state != StIdle);
  assign o_done  = (r_state == StFin);
  assign o_count = o_valid ? w_pop : 6'd0;

endmodule

// File: tb/tb_req_encoder_32x5.sv
// Scoreboard bench for req_encoder_32x5: three instances (LSB-first, MSB-first, masked) share the
// stimulus; each has its own expected-index queue drained by a monitor.
module tb_req_encoder_32x5;

  localparam int N = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        load  = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] d     = '0;

  logic [N-1:0] valid, busy, done;
  logic [4:0]   idx   [N];
  logic [5:0]   count [N];

  always #5 clk = ~clk;

  req_encoder_32x5 #(.MSB_FIRST(1'b0), .MASK(32'hFFFF_FFFF)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_d(d), .i_ready(ready),
    .o_valid(valid[0]), .o_idx(idx[0]), .o_busy(busy[0]), .o_done(done[0]), .o_count(count[0])
  );
  req_encoder_32x5 #(.MSB_FIRST(1'b1), .MASK(32'hFFFF_FFFF)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_d(d), .i_ready(ready),
    .o_valid(valid[1]), .o_idx(idx[1]), .o_busy(busy[1]), .o_done(done[1]), .o_count(count[1])
  );
  req_encoder_32x5 #(.MSB_FIRST(1'b0), .MASK(32'h0000_FFFF)) u_msk (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_d(d), .i_ready(ready),
    .o_valid(valid[2]), .o_idx(idx[2]), .o_busy(busy[2]), .o_done(done[2]), .o_count(count[2])
  );

  typedef struct packed {
    logic       done;
    logic [4:0] idx;
    logic [5:0] count;
  } exp_t;

  exp_t sb [N][$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] mask_of(input int k);
    return (k == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic int popc(input logic [31:0] v);
    int n = 0;
    for (int b = 0; b < 32; b++) if (v[b]) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: list set bit positions, order them, each emitted with the remaining pending count.
  task automatic push_model(input logic [31:0] v);
    for (int k = 0; k < N; k++) begin
      int   pos[$];
      exp_t e;
      logic [31:0] m = v & mask_of(k);
      for (int b = 0; b < 32; b++) if (m[b]) pos.push_back(b);
      if (k == 1) pos.reverse();
      for (int j = 0; j < pos.size(); j++) begin
        e.done  = 1'b0;
        e.idx   = 5'(pos[j]);
        e.count = 6'(pos.size() - j);
        sb[k].push_back(e);
      end
      e.done = 1'b1; e.idx = '0; e.count = '0;
      sb[k].push_back(e);
    end
  endtask

  // Monitor samples shortly before the active falling edge, so ready is the value the DUT will see.
  initial begin
    logic [N-1:0] prev_done;
    exp_t e;
    prev_done = '0;
    forever begin
      @(posedge clk);
      #3;
      if (rst_n) begin
        for (int k = 0; k < N; k++) begin
          if (valid[k]) begin
            if (sb[k].size() == 0) begin
              check($sformatf("dut%0d unexpected_valid", k), 32'(idx[k]), 32'hFFFF_FFFF);
            end else begin
              e = sb[k][0];
              check($sformatf("dut%0d valid_vs_done_item", k), 32'(e.done), 32'd0);
              check($sformatf("dut%0d idx", k), 32'(idx[k]), 32'(e.idx));
              check($sformatf("dut%0d count", k), 32'(count[k]), 32'(e.count));
              if (ready) void'(sb[k].pop_front());
            end
          end else begin
            check($sformatf("dut%0d idx_when_invalid", k), 32'(idx[k]), 32'd0);
            check($sformatf("dut%0d count_when_invalid", k), 32'(count[k]), 32'd0);
            if (done[k]) begin
              check($sformatf("dut%0d busy_during_done", k), 32'(busy[k]), 32'd1);
              if (sb[k].size() == 0) begin
                check($sformatf("dut%0d unexpected_done", k), 32'd1, 32'd0);
              end else begin
                e = sb[k].pop_front();
                check($sformatf("dut%0d done_early", k), 32'(e.done), 32'd1);
              end
            end
          end
          if (prev_done[k]) check($sformatf("dut%0d idle_after_done", k), 32'(busy[k]), 32'd0);
        end
      end
      prev_done = rst_n ? done : '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy != '0 && n < 300) begin
      tick();
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  // READY held high: DUT k must show DONE exactly kk+1 rising edges after the capture edge.
  task automatic run_fast(input logic [31:0] v);
    int kk[N];
    int maxk = 0;
    wait_idle();
    ready = 1'b1;
    load  = 1'b1;
    d     = v;
    push_model(v);
    tick();
    load = 1'b0;
    for (int k = 0; k < N; k++) begin
      kk[k] = popc(v & mask_of(k));
      if (kk[k] > maxk) maxk = kk[k];
    end
    for (int p = 1; p <= maxk + 2; p++) begin
      for (int k = 0; k < N; k++) begin
        if (p <= kk[k] + 1) begin
          check($sformatf("dut%0d done_timing p%0d", k, p), 32'(done[k]), 32'(p == kk[k] + 1));
          check($sformatf("dut%0d busy_timing p%0d", k, p), 32'(busy[k]), 32'd1);
        end else begin
          check($sformatf("dut%0d idle_timing p%0d", k, p), 32'(busy[k]), 32'd0);
        end
      end
      if (p < maxk + 2) tick();
    end
  endtask

  task automatic run_random(input logic [31:0] v);
    int n = 0;
    wait_idle();
    load = 1'b1;
    d    = v;
    push_model(v);
    ready = 1'($urandom_range(0, 3) != 0);
    tick();
    load = 1'b0;
    d    = $urandom;
    while (busy != '0 && n < 300) begin
      ready = 1'($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    check("random_drain", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("reset valid", 32'(valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset count0", 32'(count[0]), 32'd0);
    #12 rst_n = 1'b1;
    tick();

    run_fast(32'h8000_0011);
    run_fast(32'hFFFF_0000);
    run_fast(32'hFFFF_FFFF);
    run_fast(32'h0000_0000);
    run_fast(32'h0000_0001);

    // Back-pressure: index and count must hold while READY is low.
    wait_idle();
    ready = 1'b0;
    load  = 1'b1;
    d     = 32'h0000_0006;
    push_model(32'h0000_0006);
    tick();
    load = 1'b0;
    repeat (5) begin
      check("bp idx", 32'(idx[0]), 32'd1);
      check("bp count", 32'(count[0]), 32'd2);
      tick();
    end
    ready = 1'b1;
    wait_idle();

    // LOAD while scanning must be ignored.
    ready = 1'b0;
    load  = 1'b1;
    d     = 32'h0000_0003;
    push_model(32'h0000_0003);
    tick();
    d = 32'hFFFF_FFFF;
    tick();
    tick();
    load  = 1'b0;
    ready = 1'b1;
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      logic [31:0] v;
      v = $urandom & $urandom;
      if (i == 5) v = 32'h8000_0001;
      if (i == 9) v = 32'hFFFF_FFFF;
      run_random(v);
    end

    // Asynchronous reset mid-scan.
    wait_idle();
    ready = 1'b0;
    load  = 1'b1;
    d     = 32'h0000_00F0;
    push_model(32'h0000_00F0);
    tick();
    load = 1'b0;
    tick();
    check("pre_reset valid", 32'(valid[0]), 32'd1);
    #1;
    for (int k = 0; k < N; k++) sb[k].delete();
    rst_n = 1'b0;
    #1;
    check("async_rst valid", 32'(valid), 32'd0);
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst done", 32'(done), 32'd0);
    check("async_rst count0", 32'(count[0]), 32'd0);
    check("async_rst idx0", 32'(idx[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst idle", 32'(busy), 32'd0);
      check("post_rst no_valid", 32'(valid), 32'd0);
    end

    // Reset released while LOAD is high: capture only at the next falling edge.
    rst_n = 1'b0;
    load  = 1'b1;
    d     = 32'h0000_0005;
    tick();
    rst_n = 1'b1;
    push_model(32'h0000_0005);
    #1;
    check("rst_release no_capture", 32'(busy), 32'd0);
    tick();
    load = 1'b0;
    check("rst_release capture", 32'(busy), 32'h7);
    wait_idle();

    tick();
    tick();
    for (int k = 0; k < N; k++) check($sformatf("dut%0d sb_empty", k), 32'(sb[k].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
